muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS datapath. It implements MULT, MULTU, DIV and DIVU with architectural HI/LO registers, plus MTHI/MTLO writes. It sits beside the single-cycle ALU and is the parametrised, multi-cycle successor to it. The unit takes operands from the register-file read ports and holds the control path stalled while `busy` is high.

---
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_muldiv_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the datapath and muldiv_unit.
// The datapath drives the master side and the unit is the slave.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fix at the end.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic          clock,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]         state;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic               sgn_op;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic               neg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               div_zero;
    logic               last_iter;

    assign sgn_op = ~bus.op[0];
    assign a_abs  = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_abs  = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Multiply: acc = {running upper half, remaining multiplier bits}.
    assign mul_sum = acc[0]
                   ? {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb}
                   : {1'b0, acc[2*WIDTH-1:WIDTH]};

    // Divide: acc low half shifts dividend bits out and quotient bits in.
    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opb};
    assign div_diff  = div_shift[WIDTH-1:0] - opb;

    assign neg       = sign_a ^ sign_b;
    assign prod_fix  = neg ? -acc : acc;
    assign quo_fix   = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix   = sign_a ? -rem : rem;
    assign div_zero  = (opb == '0);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            a_raw  <= '0;
            opb    <= '0;
            acc    <= '0;
            rem    <= '0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= CALC;
                        busy_q <= 1'b1;
                        is_div <= bus.op[1];
                        sign_a <= sgn_op & bus.a[WIDTH-1];
                        sign_b <= sgn_op & bus.b[WIDTH-1];
                        a_raw  <= bus.a;
                        rem    <= '0;
                        cnt    <= '0;
                        if (bus.op[1]) begin
                            opb <= b_abs;
                            acc <= {{WIDTH{1'b0}}, a_abs};
                        end else begin
                            opb <= a_abs;
                            acc <= {{WIDTH{1'b0}}, b_abs};
                        end
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        rem <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (last_iter) state <= FIX;
                end
                FIX: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    if (!is_div) begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else if (div_zero) begin
                        hi_q <= a_raw;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model plus
// literal expectations for each operation and control corner case.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic chk_en = 1'b0;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, {hi, lo}.
    function automatic logic [63:0] ref_res(input logic [1:0] o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint q;
        longint r;
        logic [63:0] p;
        p = '0;
        case (o)
            MULT:  p = 64'(sx * sy);
            MULTU: p = {32'b0, x} * {32'b0, y};
            DIV: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else p = {x % y, x / y};
            end
        endcase
        return p;
    endfunction

    // Timing model: result lands W+1 edges after an accepted start.
    int          m_cnt;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_done;
    logic [63:0] m_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                end
            end else if (bus.start) begin
                m_pend <= ref_res(bus.op, bus.a, bus.b);
                m_cnt  <= W + 1;
            end else begin
                if (bus.hi_we) m_hi <= bus.wdata;
                if (bus.lo_we) m_lo <= bus.wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("cyc_busy", 32'(bus.busy), 32'(m_cnt > 0));
            check("cyc_done", 32'(bus.done), 32'(m_done));
            check("cyc_hi", bus.hi, m_hi);
            check("cyc_lo", bus.lo, m_lo);
        end
    end

    task automatic pulse_start(input logic [1:0] o, input logic [31:0] x,
                               input logic [31:0] y);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el);
        int k = 0;
        int nb = 0;
        pulse_start(o, x, y);
        while (bus.done !== 1'b1 && k < 100) begin
            if (bus.busy === 1'b1) nb++;
            @(negedge clk);
            k++;
        end
        check({nm, "_latency"}, 32'(k), 32'(W + 1));
        check({nm, "_busy_cycles"}, 32'(nb), 32'(W + 1));
        check({nm, "_hi"}, bus.hi, eh);
        check({nm, "_lo"}, bus.lo, el);
        @(negedge clk);
        check({nm, "_done_1cyc"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nd;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult_minmin", MULT, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000);
        run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negdivisor", DIV, 32'd7, 32'hFFFF_FFFE,
               32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu", DIVU, 32'd100, 32'd7, 32'd2, 32'h0000_000E);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000);
        run_op("divu_zero", DIVU, 32'h1234, 32'd0,
               32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div_zero_neg", DIV, 32'hFFFF_FFF9, 32'd0,
               32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // A start while busy must not disturb the running MULTU 6*7.
        pulse_start(MULTU, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        nd = 0;
        for (int i = 5; i < 50; i++) begin
            if (bus.done === 1'b1) begin
                nd++;
                check("restart_hi", bus.hi, 32'd0);
                check("restart_lo", bus.lo, 32'd42);
            end
            @(negedge clk);
        end
        check("restart_done_count", 32'(nd), 32'd1);

        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi_hi", bus.hi, 32'hDEAD_BEEF);
        check("mthi_lo_kept", bus.lo, 32'd42);
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("mthilo_hi", bus.hi, 32'h5A5A_5A5A);
        check("mthilo_lo", bus.lo, 32'h5A5A_5A5A);

        // Writes during CALC are dropped.
        pulse_start(MULTU, 32'd3, 32'd4);
        repeat (2) @(negedge clk);
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h1111_1111;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        @(negedge clk);
        check("calc_we_hi", bus.hi, 32'h5A5A_5A5A);
        check("calc_we_lo", bus.lo, 32'h5A5A_5A5A);
        k = 0;
        while (bus.done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("calc_we_res_hi", bus.hi, 32'd0);
        check("calc_we_res_lo", bus.lo, 32'd12);

        // start wins over a same-cycle MTHI.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_CAFE;
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        check("start_prio_hi", bus.hi, 32'd0);
        k = 0;
        while (bus.done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("start_prio_res_hi", bus.hi, 32'd2);
        check("start_prio_res_lo", bus.lo, 32'h0000_000E);

        // Asynchronous abort in the middle of a DIV.
        pulse_start(DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", DIVU, 32'd100, 32'd7, 32'd2, 32'h0000_000E);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
